// File: rtl/s2_demux_reg.sv
// rtl/s2_demux_reg.sv - registered 1-to-4 distributor with per-lane valid/ack holding registers
module s2_demux_reg #(
  parameter int N = 1
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic [N-1:0] DIN,
  input  logic         IN_VALID,
  input  logic         A1,
  input  logic         B1,
  input  logic         A0,
  input  logic         B0,
  output logic         IN_READY,
  input  logic [3:0]   ACK,
  output logic [N-1:0] Q00,
  output logic [N-1:0] Q01,
  output logic [N-1:0] Q10,
  output logic [N-1:0] Q11,
  output logic [3:0]   VALID,
  output logic [2:0]   COUNT
);

  logic [1:0]   sel;
  logic         wr;
  logic [3:0]   wr_oh;
  logic [3:0]   acked;
  logic [2:0]   dec;
  logic [N-1:0] q [4];

  assign sel      = {A1 | B1, A0 & B0};
  assign IN_READY = ~VALID[sel] | ACK[sel];
  assign wr       = IN_VALID & IN_READY;
  assign wr_oh    = wr ? (4'b0001 << sel) : 4'b0000;
  assign acked    = ACK & VALID;

  // A same-lane write+ack counts as +1 write and -1 consume, netting zero.
  always_comb begin
    dec = '0;
    for (int i = 0; i < 4; i++) begin
      dec = dec + {2'b00, acked[i]};
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int i = 0; i < 4; i++) begin
        q[i] <= '0;
      end
      VALID <= 4'b0000;
      COUNT <= 3'd0;
    end else begin
      if (wr) begin
        q[sel] <= DIN;
      end
      VALID <= (VALID & ~acked) | wr_oh;
      COUNT <= COUNT + {2'b00, wr} - dec;
    end
  end

  assign Q00 = q[0];
  assign Q01 = q[1];
  assign Q10 = q[2];
  assign Q11 = q[3];

endmodule

// File: tb/tb_s2_demux_reg.sv
// tb/tb_s2_demux_reg.sv - randomized self-checking bench for s2_demux_reg
module tb_s2_demux_reg;

  logic       CLK = 1'b0;
  logic       CLR, IN_VALID, A1, B1, A0, B0, IN_READY;
  logic [7:0] DIN, Q00, Q01, Q10, Q11;
  logic [3:0] ACK, VALID;
  logic [2:0] COUNT;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq [4];
  bit         mv [4];
  bit         known = 0;

  s2_demux_reg #(.N(8)) dut (
    .CLK(CLK), .CLR(CLR), .DIN(DIN), .IN_VALID(IN_VALID),
    .A1(A1), .B1(B1), .A0(A0), .B0(B0), .IN_READY(IN_READY),
    .ACK(ACK), .Q00(Q00), .Q01(Q01), .Q10(Q10), .Q11(Q11),
    .VALID(VALID), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int lane_of(input bit a1, input bit b1, input bit a0, input bit b0);
    return ((a1 || b1) ? 2 : 0) + ((a0 && b0) ? 1 : 0);
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 4; i++) c += mv[i];
    return c;
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mv[i];
    return v;
  endfunction

  task automatic step(input bit clr, input logic [7:0] din, input bit iv,
                      input bit a1, input bit b1, input bit a0, input bit b0,
                      input logic [3:0] ack);
    int  l;
    bit  rdy;
    int  pc;
    CLR = clr; DIN = din; IN_VALID = iv;
    A1 = a1; B1 = b1; A0 = a0; B0 = b0; ACK = ack;
    l   = lane_of(a1, b1, a0, b0);
    rdy = !mv[l] || ack[l];
    #1;
    if (known) chk("in_ready", {31'd0, IN_READY}, {31'd0, rdy});
    @(posedge CLK);
    if (clr) begin
      for (int i = 0; i < 4; i++) begin
        mq[i] = 8'h00;
        mv[i] = 0;
      end
      known = 1;
    end else begin
      for (int i = 0; i < 4; i++) if (ack[i]) mv[i] = 0;
      if (iv && rdy) begin
        mq[l] = din;
        mv[l] = 1;
      end
    end
    #1;
    chk("q00", {24'd0, Q00}, {24'd0, mq[0]});
    chk("q01", {24'd0, Q01}, {24'd0, mq[1]});
    chk("q10", {24'd0, Q10}, {24'd0, mq[2]});
    chk("q11", {24'd0, Q11}, {24'd0, mq[3]});
    chk("valid", {28'd0, VALID}, {28'd0, model_valid()});
    chk("count", {29'd0, COUNT}, model_count());
    pc = 0;
    for (int i = 0; i < 4; i++) pc += VALID[i];
    chk("count_popcount", {29'd0, COUNT}, pc);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mq[i] = 8'h00;
      mv[i] = 0;
    end
    CLR = 1'b1; DIN = 8'h00; IN_VALID = 1'b0;
    A1 = 1'b0; B1 = 1'b0; A0 = 1'b0; B0 = 1'b0; ACK = 4'b0000;

    // reset held two cycles with a live write attempt
    step(1, 8'hFF, 1, 0, 0, 0, 0, 4'b0000);
    step(1, 8'hFF, 1, 0, 0, 0, 0, 4'b0000);
    CLR = 1'b0; IN_VALID = 1'b0;
    #1;
    chk("reset_valid", {28'd0, VALID}, 32'h0);
    chk("reset_count", {29'd0, COUNT}, 32'h0);
    chk("reset_ready", {31'd0, IN_READY}, 32'h1);

    // select decode
    step(0, 8'h11, 1, 0, 0, 1, 0, 4'b0000);
    step(0, 8'h22, 1, 0, 1, 0, 0, 4'b0000);
    step(0, 8'h33, 1, 1, 1, 1, 1, 4'b0000);
    step(0, 8'h44, 1, 0, 0, 1, 1, 4'b0000);
    chk("dec_q00", {24'd0, Q00}, 32'h11);
    chk("dec_q01", {24'd0, Q01}, 32'h44);
    chk("dec_q10", {24'd0, Q10}, 32'h22);
    chk("dec_q11", {24'd0, Q11}, 32'h33);
    chk("dec_valid", {28'd0, VALID}, 32'hF);
    chk("dec_count", {29'd0, COUNT}, 32'd4);

    // full-lane backpressure on lane 2
    CLR = 0; DIN = 8'hAA; IN_VALID = 1; A1 = 1; B1 = 0; A0 = 0; B0 = 0; ACK = 4'b0000;
    #1;
    chk("bp_ready", {31'd0, IN_READY}, 32'h0);
    step(0, 8'hAA, 1, 1, 0, 0, 0, 4'b0000);
    chk("bp_q10", {24'd0, Q10}, 32'h22);
    chk("bp_count", {29'd0, COUNT}, 32'd4);

    // pass-through refill on lane 2
    DIN = 8'hBB; ACK = 4'b0100;
    #1;
    chk("pt_ready", {31'd0, IN_READY}, 32'h1);
    step(0, 8'hBB, 1, 1, 0, 0, 0, 4'b0100);
    chk("pt_q10", {24'd0, Q10}, 32'hBB);
    chk("pt_valid", {28'd0, VALID}, 32'hF);
    chk("pt_count", {29'd0, COUNT}, 32'd4);

    // multi-ack, then ack on an empty lane
    step(0, 8'h00, 0, 0, 0, 0, 0, 4'b1011);
    chk("mack_valid", {28'd0, VALID}, 32'h4);
    chk("mack_count", {29'd0, COUNT}, 32'd1);
    chk("mack_q00", {24'd0, Q00}, 32'h11);
    chk("mack_q11", {24'd0, Q11}, 32'h33);
    step(0, 8'h00, 0, 0, 0, 0, 0, 4'b0001);
    chk("empty_ack_valid", {28'd0, VALID}, 32'h4);
    chk("empty_ack_count", {29'd0, COUNT}, 32'd1);

    // mid-operation reset with concurrent write and ack
    step(0, 8'h55, 1, 0, 0, 1, 1, 4'b0000);
    chk("pre_clr_valid", {28'd0, VALID}, 32'h6);
    chk("pre_clr_count", {29'd0, COUNT}, 32'd2);
    step(1, 8'h66, 1, 0, 0, 0, 0, 4'b0010);
    chk("mclr_valid", {28'd0, VALID}, 32'h0);
    chk("mclr_count", {29'd0, COUNT}, 32'd0);
    chk("mclr_q01", {24'd0, Q01}, 32'h0);
    chk("mclr_q10", {24'd0, Q10}, 32'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 40) == 0), 8'($urandom), bit'($urandom_range(0, 3) != 0),
           bit'($urandom), bit'($urandom), bit'($urandom), bit'($urandom),
           4'($urandom & $urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
